// File: rtl/shift_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_ram_ctrl
// Description : Line-delay controller for a simple dual-port RAM. A single
//               circular pointer serves as both write and read address, so
//               each accepted sample comes back exactly DEPTH strobes later.
//               Read data is qualified by a tag pipe that tracks RAM latency.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ram_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int DEPTH       = 1024,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clken,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  primed,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int                    c_cnt_width = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_last  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one   = ADDR_WIDTH'(1);
    localparam logic [c_cnt_width-1:0] c_cnt_full = c_cnt_width'(DEPTH);
    localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(DEPTH - 1);
    localparam logic [c_cnt_width-1:0] c_cnt_one  = c_cnt_width'(1);

    localparam logic [0:0] c_st_fill = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic                   w_accept;
    logic                   w_clear;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic [c_cnt_width-1:0] r_cnt;
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   w_primed;
    logic [RAM_LATENCY-1:0] r_tag_acc;
    logic [RAM_LATENCY-1:0] r_tag_prm;
    logic                   w_tag_fire;
    logic                   r_cap_fire;
    logic [DATA_WIDTH-1:0]  r_cap_data;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_dout_valid;

    // A sample is taken only when neither reset nor flush competes with it.
    assign w_accept = clken & ~flush & ~reset;
    assign w_clear  = reset | flush;

    assign ram_we     = w_accept;
    assign ram_re     = w_accept;
    assign ram_waddr  = r_ptr;
    assign ram_raddr  = r_ptr;
    assign ram_wdata  = din;
    assign primed     = w_primed;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

    // Circular pointer over 0..DEPTH-1; explicit wrap so DEPTH may be non-pow2.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (r_ptr == c_ptr_last) ? '0 : r_ptr + c_ptr_one;
        end
    end

    // Saturating fill counter of samples accepted since reset/flush.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cnt <= '0;
        end else if (w_accept && (r_cnt != c_cnt_full)) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // Fill/run state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fill;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN is entered on the same edge the counter reaches DEPTH.
    always_comb begin
        w_state_nxt = r_state;
        w_primed    = 1'b0;
        case (r_state)
            c_st_fill: begin
                if (w_accept && (r_cnt == c_cnt_last)) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                w_primed = 1'b1;
            end
            default: begin
                w_state_nxt = c_st_fill;
            end
        endcase
        if (flush) begin
            w_state_nxt = c_st_fill;
        end
    end

    // Tag pipe: one {accepted, primed_at_accept} entry per clock, RAM_LATENCY deep,
    // so the exiting tag lines up with the read data it describes.
    generate
        if (RAM_LATENCY == 1) begin : g_tag_single
            // Single-stage tag register.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_tag_acc <= '0;
                    r_tag_prm <= '0;
                end else begin
                    r_tag_acc <= w_accept;
                    r_tag_prm <= w_primed;
                end
            end
        end else begin : g_tag_multi
            // Multi-stage tag shift register.
            always_ff @(posedge clk) begin
                if (w_clear) begin
                    r_tag_acc <= '0;
                    r_tag_prm <= '0;
                end else begin
                    r_tag_acc <= {r_tag_acc[RAM_LATENCY-2:0], w_accept};
                    r_tag_prm <= {r_tag_prm[RAM_LATENCY-2:0], w_primed};
                end
            end
        end
    endgenerate

    // Only reads issued while already primed carry real delayed data.
    assign w_tag_fire = r_tag_acc[RAM_LATENCY-1] & r_tag_prm[RAM_LATENCY-1];

    // Capture read data as the tag exits; the extra stage gives the
    // N+RAM_LATENCY+1 output timing and isolates ram_rdata from dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_fire <= 1'b0;
            r_cap_data <= '0;
        end else begin
            r_cap_fire <= w_tag_fire & ~flush;
            if (w_tag_fire) begin
                r_cap_data <= ram_rdata;
            end
        end
    end

    // Output register: dout updates only with primed data; flush keeps dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (flush) begin
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= r_cap_fire;
            if (r_cap_fire) begin
                r_dout <= r_cap_data;
            end
        end
    end

endmodule
`default_nettype wire
